// File: rtl/rep_mul_sequencer.sv
// ---------------------------------------------------------------------------
// rep_mul_sequencer
//
// Operand sequencer for the repeated-addition multiplier engine.
// Each operand pair accepted on the input stream is handed to the engine in
// a fixed sequence: clear, start pulse, A on the load bus, then B on the load
// bus. The sequencer then waits for the engine's done level, captures the
// product and offers it on the output stream. If done does not arrive within
// TIMEOUT wait cycles, it returns an error result instead.
//
// Optional feature (compile-time macro REP_MUL_ZERO_BYPASS_EN):
//   When this macro is defined, a pair with a zero operand skips the engine
//   and goes straight to the output stage with product 0.
//
// Parameters
//   W        operand, bus and product width
//   TIMEOUT  maximum number of WAIT cycles before the operation is aborted
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     sequencer can accept a pair (idle)
//   in_a         multiplicand
//   in_b         multiplier (repeat count)
//   mul_rst_n    engine clear, active low (low only in CLR)
//   mul_start    engine start pulse (high only in START)
//   mul_bus      engine shared load bus (A in SEND_A, B in SEND_B, else 0)
//   mul_done     engine done level (sampled only in WAIT)
//   mul_product  engine product register
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_prod     product modulo 2^W (0 on timeout)
//   out_err      result was aborted by the done timeout
// ---------------------------------------------------------------------------
module rep_mul_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 131071
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         mul_rst_n,
  output logic         mul_start,
  output logic [W-1:0] mul_bus,
  input  logic         mul_done,
  input  logic [W-1:0] mul_product,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_prod,
  output logic         out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLR    = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] SEND_A = 3'd3;
  localparam logic [2:0] SEND_B = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] OUT    = 3'd6;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          zero_op;
  logic          timeout_hit;

  assign accept      = in_valid && in_ready;
  assign timeout_hit = (cnt == CNT_LAST);

`ifdef REP_MUL_ZERO_BYPASS_EN
  // A zero operand means a zero product; the engine is not needed, and it
  // would otherwise wrap on a zero repeat count.
  assign zero_op = (in_a == '0) || (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path through the case infers a latch.
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = zero_op ? OUT : CLR;
      CLR:     state_n = START;
      START:   state_n = SEND_A;
      SEND_A:  state_n = SEND_B;
      SEND_B:  state_n = WAIT;
      WAIT:    if (mul_done || timeout_hit) state_n = OUT;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // All outputs are decoded from the next state and registered, so each one
  // changes only at a clock edge and is stable for the whole cycle of its state.
  // in_ready resets to 1: the sequencer is idle and ready as soon as reset
  // is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mul_rst_n <= 1'b0;
      mul_start <= 1'b0;
      mul_bus   <= '0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_err   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples the
      // values from before this edge.
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      mul_rst_n <= (state_n != CLR);
      mul_start <= (state_n == START);
      out_valid <= (state_n == OUT);
      mul_bus   <= (state_n == SEND_A) ? a_q :
                   (state_n == SEND_B) ? b_q : '0;

      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end

      // The counter starts from 0 on the edge that enters WAIT. It stops on
      // the edge that leaves WAIT.
      if (state == SEND_B) begin
        cnt <= '0;
      end else if (state == WAIT && !mul_done && !timeout_hit) begin
        cnt <= cnt + 1'b1;
      end

      if (state == IDLE && accept && zero_op) begin
        out_prod <= '0;
        out_err  <= 1'b0;
      end else if (state == WAIT) begin
        if (mul_done) begin
          out_prod <= mul_product;
          out_err  <= 1'b0;
        end else if (timeout_hit) begin
          out_prod <= '0;
          out_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rep_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rep_mul_sequencer
//
// Self-checking bench for rep_mul_sequencer. It runs with TIMEOUT=8.
// The engine is modelled at transaction level. For each operation the bench
// drives done and the product with a chosen done latency k, where k=0 means
// the engine never asserts done. The expected result is computed with plain
// arithmetic:
//   - a normal operation gives a*b mod 2^16 with no error,
//   - a timeout gives product 0 with the error flag set,
//   - a bypassed zero operand gives product 0 with no error.
// Define REP_MUL_ZERO_BYPASS_EN when compiling this bench if the RTL is
// built with that macro.
// ---------------------------------------------------------------------------
module tb_rep_mul_sequencer;

  localparam int W  = 16;
  localparam int TO = 8;
`ifdef REP_MUL_ZERO_BYPASS_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         mul_rst_n;
  logic         mul_start;
  logic [W-1:0] mul_bus;
  logic         mul_done;
  logic [W-1:0] mul_product;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic         out_err;

  int errors = 0;
  int checks = 0;

  rep_mul_sequencer #(.W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_rst_n  (mul_rst_n),
    .mul_start  (mul_start),
    .mul_bus    (mul_bus),
    .mul_done   (mul_done),
    .mul_product(mul_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction.
  //   k      WAIT cycle in which the engine first raises done (0 = never)
  //   hold   number of extra cycles that out_ready is held low once the
  //          result is valid
  //   stale  keep the previous done high (with a bogus product) through
  //          CLR..SEND_B
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int k, input int hold, input bit stale);
    logic [W-1:0] exp_prod;
    logic         exp_err;
    logic [W-1:0] prod_ab;
    bit           bypass;
    bit           got_valid;
    bypass   = ZB && (a == '0 || b == '0);
    prod_ab  = a * b;
    exp_prod = prod_ab;
    exp_err  = 1'b0;
    if (!bypass && k == 0) begin
      exp_prod = '0;
      exp_err  = 1'b1;
    end

    check("idle_in_ready", in_ready, 1);
    if (stale) begin
      mul_done    = 1'b1;
      mul_product = 16'hDEAD;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();                                   // handshake at E0
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);

    if (bypass) begin
      check("bypass_valid", out_valid, 1);
      check("bypass_no_start", mul_start, 0);
      check("bypass_no_clr", mul_rst_n, 1);
      check("bypass_bus", mul_bus, 0);
    end else begin
      check("clr_rst_n", mul_rst_n, 0);
      check("clr_in_ready", in_ready, 0);
      check("clr_start", mul_start, 0);
      if (!stale) mul_done = 1'b0;
      step();                                 // START
      check("start_pulse", mul_start, 1);
      check("start_bus", mul_bus, 0);
      check("start_rst_n", mul_rst_n, 1);
      step();                                 // SEND_A
      check("send_a_bus", mul_bus, a);
      check("send_a_start", mul_start, 0);
      #4;
      check("send_a_stable", mul_bus, a);
      step();                                 // SEND_B
      check("send_b_bus", mul_bus, b);
      step();                                 // first WAIT cycle
      check("wait_bus", mul_bus, 0);
      check("wait_no_valid", out_valid, 0);
      got_valid = 1'b0;
      for (int j = 1; j <= TO + 1 && !got_valid; j++) begin
        if (k != 0 && j >= k) begin
          mul_done    = 1'b1;
          mul_product = prod_ab;
        end else begin
          mul_done    = 1'b0;
          mul_product = W'($urandom);
        end
        step();
        if ((k != 0 && j == k) || (k == 0 && j == TO)) begin
          check("valid_at_e4_plus_k", out_valid, 1);
          got_valid = 1'b1;
        end else begin
          check("no_early_valid", out_valid, 0);
        end
      end
      mul_product = W'($urandom);             // the result must already be held
    end

    check("out_prod", out_prod, exp_prod);
    check("out_err", out_err, exp_err);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", out_valid, 1);
      check("hold_prod", out_prod, exp_prod);
      check("hold_err", out_err, exp_err);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();                                   // result consumed
    out_ready = 1'b0;
    check("ready_after_accept", in_ready, 1);
    check("valid_dropped", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           rk;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    out_ready   = 1'b0;

    // Reset state.
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_bus", mul_bus, 0);
    check("rst_mul_rst_n", mul_rst_n, 0);
    check("rst_out_prod", out_prod, 0);
    check("rst_out_err", out_err, 0);
    #19 rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_mul_rst_n", mul_rst_n, 1);

    // Basic multiply.
    do_op(16'd7, 16'd5, 5, 0, 1'b0);
    // Back-pressure.
    do_op(16'd3, 16'd4, 2, 10, 1'b0);
    // Stale done: done stays high from the previous operation.
    do_op(16'd6, 16'd11, 3, 1, 1'b1);
    // Timeout.
    do_op(16'd9, 16'd9, 0, 2, 1'b0);
    // Zero operand (bypassed or full sequence, depending on the build).
    do_op(16'd0, 16'd100, 3, 0, 1'b0);
    // Product wraps modulo 2^16.
    do_op(16'hFFFF, 16'd3, 1, 0, 1'b0);

    // Reset asserted during SEND_A.
    in_valid = 1'b1;
    in_a     = 16'd11;
    in_b     = 16'd13;
    step();
    in_valid = 1'b0;
    mul_done = 1'b0;
    step();                                   // START
    step();                                   // SEND_A
    check("pre_rst_bus", mul_bus, 16'd11);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bus", mul_bus, 0);
    check("async_rst_start", mul_start, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_mul_rst_n", mul_rst_n, 0);
    #10 rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    step();
    check("rel_bus", mul_bus, 0);
    check("rel_mul_rst_n", mul_rst_n, 1);
    do_op(16'd2, 16'd9, 3, 0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      rk = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      do_op(ra, rb, rk, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
